// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: merges load-use, redirect,
// data-memory busy and trap requests into per-stage enables, flushes and PC select.
module pipeline_hazard_ctrl #(
    parameter int TRAP_LAT = 2,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             lu_stall,
    input  logic             redirect,
    input  logic             dmem_busy,
    input  logic             trap_req,
    output logic             trap_ack,
    output logic             pc_en,
    output logic [1:0]       pc_sel,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_FREEZE = 2'd1,
        ST_TRAP   = 2'd2
    } state_t;

    localparam int DW = (TRAP_LAT > 1) ? $clog2(TRAP_LAT) : 1;
    localparam logic [DW-1:0]    DRAIN_LOAD = DW'(TRAP_LAT - 1);
    localparam logic [DW-1:0]    DRAIN_ONE  = DW'(1'b1);
    localparam logic [DW-1:0]    DRAIN_ZERO = {DW{1'b0}};
    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1'b1);
    localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};

    // Saturating increment: holds at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] r;
        if (v == CNT_MAX) begin
            r = v;
        end else begin
            r = v + CNT_ONE;
        end
        return r;
    endfunction

    state_t           state_r, state_nxt_s;
    logic [DW-1:0]    drain_r, drain_nxt_s;
    logic [CNT_W-1:0] stall_cnt_r, flush_cnt_r;
    logic             flush_evt_s, stall_evt_s;
    logic             trap_ack_s, pc_en_s;
    logic [1:0]       pc_sel_s;
    logic             ifid_en_s, idex_en_s, exmem_en_s, memwb_en_s;
    logic             ifid_flush_s, idex_flush_s, exmem_flush_s;

    // Next-state and same-cycle control decode.
    always_comb begin
        state_nxt_s   = state_r;
        drain_nxt_s   = drain_r;
        flush_evt_s   = 1'b0;
        trap_ack_s    = 1'b0;
        pc_en_s       = 1'b0;
        pc_sel_s      = 2'd0;
        ifid_en_s     = 1'b0;
        idex_en_s     = 1'b0;
        exmem_en_s    = 1'b0;
        memwb_en_s    = 1'b0;
        ifid_flush_s  = 1'b0;
        idex_flush_s  = 1'b0;
        exmem_flush_s = 1'b0;
        case (state_r)
            ST_RUN, ST_FREEZE: begin
                if (dmem_busy) begin
                    state_nxt_s = ST_FREEZE;
                end else if (trap_req) begin
                    trap_ack_s    = 1'b1;
                    pc_en_s       = 1'b1;
                    pc_sel_s      = 2'd2;
                    ifid_flush_s  = 1'b1;
                    idex_flush_s  = 1'b1;
                    exmem_flush_s = 1'b1;
                    memwb_en_s    = 1'b1;
                    flush_evt_s   = 1'b1;
                    drain_nxt_s   = DRAIN_LOAD;
                    state_nxt_s   = ST_TRAP;
                end else if (redirect) begin
                    // A concurrent load-use stall is moot: its consumer is flushed.
                    pc_en_s      = 1'b1;
                    pc_sel_s     = 2'd1;
                    ifid_flush_s = 1'b1;
                    idex_flush_s = 1'b1;
                    exmem_en_s   = 1'b1;
                    memwb_en_s   = 1'b1;
                    flush_evt_s  = 1'b1;
                    state_nxt_s  = ST_RUN;
                end else if (lu_stall) begin
                    idex_flush_s = 1'b1;
                    exmem_en_s   = 1'b1;
                    memwb_en_s   = 1'b1;
                    state_nxt_s  = ST_RUN;
                end else begin
                    pc_en_s     = 1'b1;
                    ifid_en_s   = 1'b1;
                    idex_en_s   = 1'b1;
                    exmem_en_s  = 1'b1;
                    memwb_en_s  = 1'b1;
                    state_nxt_s = ST_RUN;
                end
            end
            ST_TRAP: begin
                ifid_flush_s = 1'b1;
                idex_flush_s = 1'b1;
                if (dmem_busy) begin
                    drain_nxt_s = drain_r;
                end else begin
                    exmem_en_s = 1'b1;
                    memwb_en_s = 1'b1;
                    if (drain_r == DRAIN_ZERO) begin
                        state_nxt_s = ST_RUN;
                    end else begin
                        drain_nxt_s = drain_r - DRAIN_ONE;
                    end
                end
            end
            default: begin
                state_nxt_s = ST_RUN;
            end
        endcase
    end

    assign stall_evt_s = (state_r != ST_TRAP) && !pc_en_s;

    // Sequencer state and trap drain counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_RUN;
            drain_r <= DRAIN_ZERO;
        end else begin
            state_r <= state_nxt_s;
            drain_r <= drain_nxt_s;
        end
    end

    // Saturating stall and flush performance counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_r <= CNT_ZERO;
            flush_cnt_r <= CNT_ZERO;
        end else begin
            stall_cnt_r <= stall_evt_s ? sat_inc(stall_cnt_r) : stall_cnt_r;
            flush_cnt_r <= flush_evt_s ? sat_inc(flush_cnt_r) : flush_cnt_r;
        end
    end

    // Reset forces the safe bubble pattern without waiting for a clock.
    assign trap_ack    = rst_n & trap_ack_s;
    assign pc_en       = rst_n & pc_en_s;
    assign pc_sel      = rst_n ? pc_sel_s : 2'd0;
    assign ifid_en     = rst_n & ifid_en_s;
    assign idex_en     = rst_n & idex_en_s;
    assign exmem_en    = rst_n & exmem_en_s;
    assign memwb_en    = rst_n & memwb_en_s;
    assign ifid_flush  = ~rst_n | ifid_flush_s;
    assign idex_flush  = ~rst_n | idex_flush_s;
    assign exmem_flush = ~rst_n | exmem_flush_s;
    assign stall_cnt   = stall_cnt_r;
    assign flush_cnt   = flush_cnt_r;

endmodule
